// File: rtl/usb4_lane_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// usb4_lane_tx_serializer_if
//
// Purpose : bonded symbol handshake between the logical-layer symbol source
//           and the lane transmit serializer.
//
// Signals :
//   in_data   NUM_LANES*SYM_W  lane k symbol in bits [k*SYM_W +: SYM_W]
//   in_valid  1                source has a bonded symbol on in_data
//   in_ready  1                serializer accepts on in_valid && in_ready
//
// Modports:
//   master - symbol source (drives in_data/in_valid, observes in_ready)
//   slave  - serializer    (observes in_data/in_valid, drives in_ready)
// ---------------------------------------------------------------------------
interface usb4_lane_tx_serializer_if #(
    parameter int NUM_LANES = 2,
    parameter int SYM_W     = 8
);
    logic [NUM_LANES*SYM_W-1:0] in_data;
    logic                       in_valid;
    logic                       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/usb4_lane_tx_serializer.sv
// ---------------------------------------------------------------------------
// usb4_lane_tx_serializer
//
// Purpose : multi-lane transmit serializer. Takes one bonded parallel symbol
//           per lane through a valid/ready handshake and shifts every lane
//           out LSB-first in lockstep. Each bit is held for DIV clk cycles,
//           DIV being chosen from gen_speed when the symbol is loaded.
//
// Ports   :
//   clk        block clock
//   rst        asynchronous active-high reset
//   sym        symbol handshake (slave modport: in_data, in_valid, in_ready)
//   tx_en      transmit enable; gates new accepts, never aborts a symbol
//   gen_speed  0=Gen2, 1=Gen3, 2=Gen4, 3=reserved (behaves as Gen2)
//   lane_tx    registered serial lane outputs
//   busy       high while a symbol is being shifted
//   sym_cnt    completed symbols, wraps modulo 2^CNT_W
//
// Build option:
//   USB4_TX_SCRAMBLER_EN - when defined, each lane XORs its data bits with
//   an 11-bit LFSR (x^11 + x^9 + 1) seeded at reset to 11'h7FF ^ lane index.
//   The LFSR steps once per completed bit period and holds while idle.
//   When undefined no LFSR logic exists and data goes out unmodified.
// ---------------------------------------------------------------------------
module usb4_lane_tx_serializer #(
    parameter int   NUM_LANES = 2,
    parameter int   SYM_W     = 8,
    parameter int   GEN2_DIV  = 4,
    parameter int   GEN3_DIV  = 2,
    parameter int   GEN4_DIV  = 1,
    parameter logic IDLE_LVL  = 1'b0,
    parameter int   CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    usb4_lane_tx_serializer_if.slave      sym,
    input  logic                          tx_en,
    input  logic [1:0]                    gen_speed,
    output logic [NUM_LANES-1:0]          lane_tx,
    output logic                          busy,
    output logic [CNT_W-1:0]              sym_cnt
);

    // Divider counter only has to reach the largest DIV-1.
    localparam int MAX_DIV_23 = (GEN2_DIV > GEN3_DIV) ? GEN2_DIV : GEN3_DIV;
    localparam int MAX_DIV    = (MAX_DIV_23 > GEN4_DIV) ? MAX_DIV_23 : GEN4_DIV;
    localparam int DIV_W      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam int BIT_W      = $clog2(SYM_W);

    localparam logic [DIV_W-1:0] GEN2_M1  = DIV_W'(GEN2_DIV - 1);
    localparam logic [DIV_W-1:0] GEN3_M1  = DIV_W'(GEN3_DIV - 1);
    localparam logic [DIV_W-1:0] GEN4_M1  = DIV_W'(GEN4_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SYM_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_reg;
    logic [BIT_W-1:0]   bit_idx_reg;
    logic [DIV_W-1:0]   div_cnt_reg;
    logic [DIV_W-1:0]   div_m1_reg;     // DIV-1 latched at symbol load
    logic               busy_reg;
    logic [CNT_W-1:0]   sym_cnt_reg;

    logic [DIV_W-1:0]   sel_div_m1;
    logic               bit_end;        // last clk of the current bit period
    logic               sym_end;        // last clk of the last bit
    logic               in_ready_int;
    logic               accept;
    logic               adv;            // move to the next bit of this symbol
    logic               go_idle;        // symbol done, nothing to follow

    always_comb begin
        sel_div_m1 = GEN2_M1;
        case (gen_speed)
            2'd1:    sel_div_m1 = GEN3_M1;
            2'd2:    sel_div_m1 = GEN4_M1;
            default: sel_div_m1 = GEN2_M1;   // Gen2 and the reserved code
        endcase
    end

    assign bit_end = (state_reg == SHIFT) && (div_cnt_reg == div_m1_reg);
    assign sym_end = bit_end && (bit_idx_reg == LAST_BIT);

    // Ready is decoded from registered state so a reload can happen in the
    // final cycle of the last bit without a gap. It is forced low while rst
    // is held so nothing is offered during reset.
    assign in_ready_int = !rst && tx_en && ((state_reg == IDLE) || sym_end);
    assign accept       = sym.in_valid && in_ready_int;
    assign adv          = bit_end && !sym_end;
    assign go_idle      = sym_end && !accept;

    assign sym.in_ready = in_ready_int;
    assign busy         = busy_reg;
    assign sym_cnt      = sym_cnt_reg;

    // -----------------------------------------------------------------------
    // Control FSM: state, bit/divider counters, busy and completion counter.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_idx_reg <= '0;
            div_cnt_reg <= '0;
            div_m1_reg  <= '0;
            busy_reg    <= 1'b0;
            sym_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg   <= SHIFT;
                        busy_reg    <= 1'b1;
                        div_m1_reg  <= sel_div_m1;
                        bit_idx_reg <= '0;
                        div_cnt_reg <= '0;
                    end
                end
                SHIFT: begin
                    if (bit_end) begin
                        div_cnt_reg <= '0;
                        if (bit_idx_reg == LAST_BIT) begin
                            sym_cnt_reg <= sym_cnt_reg + CNT_W'(1);
                            bit_idx_reg <= '0;
                            if (accept) begin
                                // back-to-back: new DIV applies to this symbol
                                div_m1_reg <= sel_div_m1;
                            end else begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end else begin
                            bit_idx_reg <= bit_idx_reg + BIT_W'(1);
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Per-lane datapath. On load, bit 0 goes straight to the output register
    // and the remaining bits are kept in shreg_reg, so shreg_reg[0] is always
    // the next bit to send.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [SYM_W-1:0] lane_data;
        logic [SYM_W-1:0] shreg_reg;
        logic             tx_reg;
        logic             load_bit;
        logic             adv_bit;

        assign lane_data = sym.in_data[gi*SYM_W +: SYM_W];

`ifdef USB4_TX_SCRAMBLER_EN
        logic [10:0] lfsr_reg;
        logic [10:0] lfsr_next;

        assign lfsr_next = {lfsr_reg[9:0], lfsr_reg[10] ^ lfsr_reg[8]};

        // A load from IDLE uses the held LFSR; a back-to-back reload happens
        // on a completed bit period, so it already sees the stepped value.
        assign load_bit = lane_data[0] ^ (bit_end ? lfsr_next[10] : lfsr_reg[10]);
        assign adv_bit  = shreg_reg[0] ^ lfsr_next[10];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lfsr_reg <= 11'h7FF ^ 11'(gi);
            end else if (bit_end) begin
                lfsr_reg <= lfsr_next;
            end
        end
`else
        assign load_bit = lane_data[0];
        assign adv_bit  = shreg_reg[0];
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shreg_reg <= '0;
                tx_reg    <= IDLE_LVL;
            end else if (accept) begin
                shreg_reg <= lane_data >> 1;
                tx_reg    <= load_bit;
            end else if (adv) begin
                shreg_reg <= shreg_reg >> 1;
                tx_reg    <= adv_bit;
            end else if (go_idle) begin
                tx_reg    <= IDLE_LVL;
            end
        end

        assign lane_tx[gi] = tx_reg;
    end

endmodule

// File: tb/tb_usb4_lane_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_usb4_lane_tx_serializer
//
// Directed bench for the default build (two lanes, 8-bit symbols, dividers
// 4/2/1, idle level 0). A table of single-symbol vectors gives, per lane,
// the expected serial sequence written in transmit order (leftmost character
// is the first bit on the wire). Hand-written sequences cover back-to-back
// streaming, a mid-symbol generation change, reset mid-symbol and tx_en
// being dropped mid-symbol.
// ---------------------------------------------------------------------------
module tb_usb4_lane_tx_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_en;
    logic [1:0]  gen_speed;
    logic [1:0]  lane_tx;
    logic        busy;
    logic [15:0] sym_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    usb4_lane_tx_serializer_if #(.NUM_LANES(2), .SYM_W(8)) bus ();

    usb4_lane_tx_serializer #(
        .NUM_LANES (2),
        .SYM_W     (8),
        .GEN2_DIV  (4),
        .GEN3_DIV  (2),
        .GEN4_DIV  (1),
        .IDLE_LVL  (1'b0),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sym       (bus),
        .tx_en     (tx_en),
        .gen_speed (gen_speed),
        .lane_tx   (lane_tx),
        .busy      (busy),
        .sym_cnt   (sym_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  gen;
        logic [15:0] data;
        int          div;
        logic [7:0]  seq0;   // lane 0, transmit order: seq0[7] goes first
        logic [7:0]  seq1;   // lane 1, transmit order
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic run_vec(input int idx);
        int    n;
        int    b;
        logic [1:0] exp_lane;
        n = 8 * vecs[idx].div;
        tx_en        = 1'b1;
        gen_speed    = vecs[idx].gen;
        bus.in_data  = vecs[idx].data;
        bus.in_valid = 1'b1;
        #1;
        chk("vec_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = i / vecs[idx].div;
            exp_lane = {vecs[idx].seq1[7-b], vecs[idx].seq0[7-b]};
            chk("vec_lane", 32'(lane_tx), 32'(exp_lane));
            chk("vec_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        exp_cnt++;
        chk("vec_lane_idle", 32'(lane_tx), 32'd0);
        chk("vec_busy_end", 32'(busy), 32'd0);
        chk("vec_sym_cnt", 32'(sym_cnt), 32'(exp_cnt));
        $display("vec %0d gen=%0d data=%h done, sym_cnt=%0d", idx, vecs[idx].gen, vecs[idx].data, sym_cnt);
    endtask

    initial begin
        int   rdy_seen;
        logic e;
        logic done;

        // Gen4, 16'hA55A: lane0 5A -> 0,1,0,1,1,0,1,0 ; lane1 A5 -> 1,0,1,0,0,1,0,1
        vecs[0] = '{gen: 2'd2, data: 16'hA55A, div: 1, seq0: 8'b01011010, seq1: 8'b10100101};
        // Gen2, 8'h01 on both lanes: high for the first bit only
        vecs[1] = '{gen: 2'd0, data: 16'h0101, div: 4, seq0: 8'b10000000, seq1: 8'b10000000};
        // Gen3: lane0 81 -> 1,0,0,0,0,0,0,1 ; lane1 3C -> 0,0,1,1,1,1,0,0
        vecs[2] = '{gen: 2'd1, data: 16'h3C81, div: 2, seq0: 8'b10000001, seq1: 8'b00111100};
        // reserved code behaves as Gen2: lane0 12 -> 0,1,0,0,1,0,0,0 ; lane1 0F -> 1,1,1,1,0,0,0,0
        vecs[3] = '{gen: 2'd3, data: 16'h0F12, div: 4, seq0: 8'b01001000, seq1: 8'b11110000};

        rst          = 1'b1;
        tx_en        = 1'b0;
        gen_speed    = 2'd0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_lane", 32'(lane_tx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_cnt", 32'(sym_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready_txen0", 32'(bus.in_ready), 32'd0);
        $display("reset checks done");

        // ---------------- table-driven single symbols ----------------
        for (int v = 0; v < 4; v++) begin
            run_vec(v);
            @(negedge clk);
        end

        // ---------------- back-to-back Gen3: FF then 00 ----------------
        tx_en = 1'b1; gen_speed = 2'd1; bus.in_data = 16'hFFFF; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy_seen = 0;
        for (int i = 0; i < 32; i++) begin
            chk("b2b_lane", 32'(lane_tx), (i < 16) ? 32'd3 : 32'd0);
            chk("b2b_busy", 32'(busy), 32'd1);
            chk("b2b_ready", 32'(bus.in_ready), (i == 15 || i == 31) ? 32'd1 : 32'd0);
            if (bus.in_ready) rdy_seen++;
            if (i == 0)  bus.in_data = 16'h0000;
            if (i == 16) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        exp_cnt += 2;
        chk("b2b_ready_count", 32'(rdy_seen), 32'd2);
        chk("b2b_lane_end", 32'(lane_tx), 32'd0);
        chk("b2b_busy_end", 32'(busy), 32'd0);
        chk("b2b_cnt", 32'(sym_cnt), 32'(exp_cnt));
        $display("back-to-back Gen3 done, ready pulses=%0d", rdy_seen);
        @(negedge clk);

        // ---------------- gen change mid-symbol: Gen4 -> Gen2 ----------------
        gen_speed = 2'd2; bus.in_data = 16'h5555; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            // 55 at 1 clk/bit: 1,0,1,0,... ; then 03 at 4 clk/bit: 1,1,0,0,0,0,0,0
            e = (i < 8) ? ((i % 2) == 0) : (((i - 8) / 4) < 2);
            chk("gen_lane", 32'(lane_tx), 32'({e, e}));
            if (i == 0) begin
                gen_speed   = 2'd0;
                bus.in_data = 16'h0303;
            end
            if (i == 8) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        exp_cnt += 2;
        chk("gen_busy_end", 32'(busy), 32'd0);
        chk("gen_cnt", 32'(sym_cnt), 32'(exp_cnt));
        $display("gen change Gen4->Gen2 done");
        @(negedge clk);

        // ---------------- reset at bit 3 of a Gen2 symbol ----------------
        gen_speed = 2'd0; bus.in_data = 16'hFFFF; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (13) @(negedge clk);
        chk("mid_lane_pre", 32'(lane_tx), 32'd3);
        rst = 1'b1;
        #1;
        chk("mid_rst_lane", 32'(lane_tx), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cnt", 32'(sym_cnt), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        gen_speed = 2'd2; bus.in_data = 16'h0201; bus.in_valid = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("post_rst_bit0", 32'(lane_tx), 32'd1);   // lane0 01 bit0=1, lane1 02 bit0=0
        @(negedge clk);
        chk("post_rst_bit1", 32'(lane_tx), 32'd2);
        repeat (7) @(negedge clk);
        exp_cnt++;
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_cnt", 32'(sym_cnt), 32'(exp_cnt));
        $display("reset mid-symbol done, sym_cnt=%0d", sym_cnt);
        @(negedge clk);

        // ---------------- tx_en dropped during bit 5 (Gen2) ----------------
        tx_en = 1'b1; gen_speed = 2'd0; bus.in_data = 16'h00FF; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("txen_lane", 32'(lane_tx), 32'd1);
            chk("txen_busy", 32'(busy), 32'd1);
            if (i >= 21) chk("txen_ready", 32'(bus.in_ready), 32'd0);
            if (i == 21) begin
                tx_en        = 1'b0;
                bus.in_data  = 16'h5555;
                bus.in_valid = 1'b1;
            end
            @(negedge clk);
        end
        exp_cnt++;
        chk("txen_busy_end", 32'(busy), 32'd0);
        chk("txen_lane_end", 32'(lane_tx), 32'd0);
        chk("txen_cnt", 32'(sym_cnt), 32'(exp_cnt));
        repeat (4) begin
            @(negedge clk);
            chk("txen_hold_busy", 32'(busy), 32'd0);
            chk("txen_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        tx_en = 1'b1;
        #1;
        chk("txen_reen_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("txen_pending_busy", 32'(busy), 32'd1);
        chk("txen_pending_bit0", 32'(lane_tx), 32'd3);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        chk("txen_pending_finish", 32'(done), 32'd1);
        exp_cnt++;
        chk("txen_pending_cnt", 32'(sym_cnt), 32'(exp_cnt));
        $display("tx_en drop done, sym_cnt=%0d", sym_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
